// File: rtl/gpu_cmd_tx.sv
// CPU-side transmitter for the GPU command line: buffers (cmd, param) requests
// and emits cmd/param/0 frames aligned to the GPU's A/B/X receive slots.
module gpu_cmd_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_cmd,
  input  logic [15:0]       req_param,
  output logic [15:0]       cpuline,
  output logic              busy,
  output logic              err_opcode,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0] OPC_MIN = 16'h00C0;
  localparam logic [15:0] OPC_MAX = 16'h00C6;

  // slot_q is the slot currently on the line (the GPU samples it at the next edge)
  typedef enum logic [1:0] {
    SLOT_A = 2'd0,
    SLOT_B = 2'd1,
    SLOT_X = 2'd2
  } slot_e;

  slot_e             slot_q;
  logic              real_q;
  logic [15:0]       param_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0]  level_d;

  logic [15:0] cmd_mem   [FIFO_DEPTH];
  logic [15:0] param_mem [FIFO_DEPTH];

  logic push_hs;
  logic opcode_ok;
  logic push;
  logic pop;
  logic next_is_a;
  logic busy_d;

  always_comb begin
    push_hs   = req_valid && req_ready;
    opcode_ok = (req_cmd >= OPC_MIN) && (req_cmd <= OPC_MAX);
    push      = push_hs && opcode_ok;
    // An A slot starts after X, or after an idle B
    next_is_a = (slot_q == SLOT_X) || ((slot_q == SLOT_B) && !real_q);
    pop       = next_is_a && (level != '0);
    level_d   = level;
    case ({push, pop})
      2'b10:   level_d = level + LVL_W'(1);
      2'b01:   level_d = level - LVL_W'(1);
      default: level_d = level;
    endcase
    busy_d = (level_d != '0) || (!next_is_a && real_q);
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr_q]   <= req_cmd;
      param_mem[wr_ptr_q] <= req_param;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      slot_q     <= SLOT_A;
      real_q     <= 1'b0;
      param_q    <= '0;
      cpuline    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level      <= level_d;
      req_ready  <= (level_d != DEPTH_L);
      busy       <= busy_d;
      err_opcode <= push_hs && !opcode_ok;

      if (next_is_a) begin
        slot_q  <= SLOT_A;
        real_q  <= pop;
        cpuline <= pop ? cmd_mem[rd_ptr_q] : 16'h0000;
        if (pop) param_q <= param_mem[rd_ptr_q];
      end else if (slot_q == SLOT_A) begin
        slot_q  <= SLOT_B;
        cpuline <= real_q ? param_q : 16'h0000;
      end else begin
        slot_q  <= SLOT_X;
        cpuline <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Bench for gpu_cmd_tx: directed scenarios plus random traffic, checked every
// cycle against a word-stream model of the command line.
module tb_gpu_cmd_tx;

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_cmd;
  logic [15:0] req_param;
  logic [15:0] cpuline;
  logic        busy;
  logic        err_opcode;
  logic [3:0]  level;

  gpu_cmd_tx #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_param  (req_param),
    .cpuline    (cpuline),
    .busy       (busy),
    .err_opcode (err_opcode),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a FIFO of requests and a queue of words still owed to the line
  typedef struct {
    logic [15:0] cmd;
    logic [15:0] param;
  } req_t;

  req_t        m_fifo[$];
  logic [15:0] m_words[$];
  bit          m_next_a;
  logic [15:0] m_line;
  bit          m_busy, m_err, m_ready;
  int          m_level;
  bit          m_hs, m_tail, m_legal;
  req_t        m_r;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_fifo.delete();
      m_words.delete();
      m_next_a = 0;
      m_line   = 16'h0;
      m_busy   = 0;
      m_err    = 0;
      m_ready  = 1;
      m_level  = 0;
    end else begin
      m_hs    = req_valid && m_ready;
      m_legal = (req_cmd >= 16'h00C0) && (req_cmd <= 16'h00C6);
      m_tail  = 0;
      if (m_words.size() > 0) begin
        m_line = m_words.pop_front();
        m_tail = 1;
        if (m_words.size() == 0) m_next_a = 1;
      end else if (m_next_a) begin
        m_next_a = 0;
        if (m_fifo.size() > 0) begin
          m_r    = m_fifo.pop_front();
          m_line = m_r.cmd;
          m_words.push_back(m_r.param);
          m_words.push_back(16'h0000);
        end else begin
          m_line = 16'h0000;
        end
      end else begin
        m_line   = 16'h0000;
        m_next_a = 1;
      end
      m_err = m_hs && !m_legal;
      if (m_hs && m_legal) begin
        m_r.cmd   = req_cmd;
        m_r.param = req_param;
        m_fifo.push_back(m_r);
      end
      m_level = m_fifo.size();
      m_ready = (m_level != 8);
      m_busy  = (m_level != 0) || m_tail;
    end
  end

  bit saw_full = 0;
  logic [15:0] hist [0:8191];
  int cyc = 0;

  always @(negedge clk) begin
    chk("cpuline", 32'(cpuline), 32'(m_line));
    chk("level", 32'(level), 32'(m_level));
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("err_opcode", 32'(err_opcode), 32'(m_err));
    if (!req_ready && level == 4'd8) saw_full = 1;
    if (cyc < 8192) hist[cyc] = cpuline;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge with valid still high
  task automatic push(input logic [15:0] c, input logic [15:0] p);
    bit acc;
    acc = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_param = p;
    for (int i = 0; i < 200; i++) begin
      acc = req_ready;
      step();
      if (acc) break;
    end
    if (!acc) chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_cmd   = 16'h0;
    req_param = 16'h0;
  endtask

  task automatic wait_line(input logic [15:0] v, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 64; i++) begin
      if (cpuline == v) begin
        found = 1;
        break;
      end
      step();
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      step();
      if (level == 4'd0 && !busy && cpuline == 16'h0) quiet++;
      else quiet = 0;
    end
    chk("drain", 32'(quiet >= 4), 32'd1);
  endtask

  task automatic check_seq(input int start, input logic [15:0] exp [9], input string name);
    int idx;
    idx = -1;
    for (int i = start; i < cyc; i++) begin
      if (hist[i] == exp[0]) begin
        idx = i;
        break;
      end
    end
    chk({name, "_found"}, 32'(idx >= 0), 32'd1);
    if (idx >= 0) begin
      for (int k = 0; k < 9; k++) chk(name, 32'(hist[idx+k]), 32'(exp[k]));
    end
  endtask

  logic [15:0] burst_exp [9];
  int start_idx;
  int r;

  initial begin
    clr = 1'b0;
    idle();
    // Reset hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_line", 32'(cpuline), 32'h0);
    end
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_opcode), 32'd0);

    // Single frame on the first edge after release
    @(posedge clk);
    #1;
    clr = 1'b1;
    push(16'h00C1, 16'h0041);
    idle();
    chk("c1_t0_line", 32'(cpuline), 32'h0);
    chk("c1_t0_level", 32'(level), 32'd1);
    step();
    chk("c1_cmd", 32'(cpuline), 32'h00C1);
    chk("c1_level", 32'(level), 32'd0);
    step();
    chk("c1_param", 32'(cpuline), 32'h0041);
    chk("c1_busy_b", 32'(busy), 32'd1);
    step();
    chk("c1_x", 32'(cpuline), 32'h0);
    step();
    chk("c1_idle", 32'(cpuline), 32'h0);
    chk("c1_busy_idle", 32'(busy), 32'd0);

    // Request arriving with a B slot next waits one extra cycle
    step();
    push(16'h00C5, 16'h0000);
    idle();
    chk("c5_wait0", 32'(cpuline), 32'h0);
    step();
    chk("c5_wait1", 32'(cpuline), 32'h0);
    step();
    chk("c5_cmd", 32'(cpuline), 32'h00C5);
    step();
    chk("c5_param", 32'(cpuline), 32'h0);
    step();

    // Back-to-back burst
    start_idx = cyc;
    push(16'h00C3, 16'h0005);
    push(16'h00C4, 16'h0007);
    push(16'h00C1, 16'h0042);
    idle();
    repeat (14) step();
    burst_exp = '{16'h00C3, 16'h0005, 16'h0000, 16'h00C4, 16'h0007, 16'h0000,
                  16'h00C1, 16'h0042, 16'h0000};
    check_seq(start_idx, burst_exp, "burst");
    wait_drain();

    // Fill past capacity; ready must drop at 8 and order is kept
    for (int i = 0; i < 14; i++) push(16'h00C0 + 16'(i % 7), 16'(16'h0100 + i));
    idle();
    chk("full_seen", 32'(saw_full), 32'd1);
    wait_drain();

    // Illegal opcodes are swallowed with an error pulse
    push(16'h00C7, 16'h0001);
    idle();
    chk("ill1_err", 32'(err_opcode), 32'd1);
    chk("ill1_level", 32'(level), 32'd0);
    step();
    chk("ill1_err_clr", 32'(err_opcode), 32'd0);
    push(16'h0000, 16'h0000);
    idle();
    chk("ill2_err", 32'(err_opcode), 32'd1);
    chk("ill2_line", 32'(cpuline), 32'h0);
    step();
    chk("ill2_level", 32'(level), 32'd0);

    // Reset during the B slot of a frame with one more request queued
    push(16'h00C6, 16'h00AB);
    push(16'h00C2, 16'h0011);
    idle();
    wait_line(16'h00C6, "c6_cmd_seen");
    step();
    chk("c6_param", 32'(cpuline), 32'h00AB);
    clr = 1'b0;
    #1;
    chk("abort_line", 32'(cpuline), 32'h0);
    chk("abort_level", 32'(level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) step();
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_stale", 32'(cpuline), 32'h0);
    end

    // Random traffic with one reset pulse
    for (int i = 0; i < 1500; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      req_cmd   = (r < 8) ? 16'(16'h00C0 + 16'($urandom_range(0, 6))) : 16'($urandom);
      req_param = 16'($urandom);
      if (i == 700) clr = 1'b0;
      if (i == 703) clr = 1'b1;
      step();
    end
    idle();
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
